pad_poller: RTL and testbench

PAD_POLLER -- requirements
Module: pad_poller

---
 rtl/pad_pkg.sv | 12 +
 rtl/pad_tick_gen.sv | 28 ++
 rtl/pad_poller.sv | 131 +++++++++++++
 tb/tb_pad_poller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pad_pkg.sv
// Shared FSM state type and default configuration for the serial game-pad poller.
package pad_pkg;

  typedef enum logic [1:0] {StIdle, StLatch, StShift, StGap} pad_state_e;

  localparam int unsigned DefNumPads  = 2;
  localparam int unsigned DefNumBits  = 8;
  localparam int unsigned DefDiv      = 1000;
  localparam int unsigned DefPollGap  = 4;
  localparam bit          DefActiveLow = 1'b1;

endpackage

// File: rtl/pad_tick_gen.sv
// Single-cycle tick enable every DIV clocks; first tick lands DIV clocks after reset release.
module pad_tick_gen #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = $clog2(DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pad_poller.sv
// Polls NUM_PADS NES/SNES-style serial pads in lock-step and publishes whole frames only.
module pad_poller
  import pad_pkg::*;
#(
  parameter int unsigned NUM_PADS   = DefNumPads,
  parameter int unsigned NUM_BITS   = DefNumBits,
  parameter int unsigned DIV        = DefDiv,
  parameter int unsigned POLL_GAP   = DefPollGap,
  parameter bit          ACTIVE_LOW = DefActiveLow
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_PADS-1:0]          data,
  output logic                         latch,
  output logic                         pad_clk,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic                         valid,
  output logic [NUM_PADS-1:0]          changed
);

  // One counter serves the latch, shift and gap phases.
  localparam int unsigned CntMax = (2 * NUM_BITS > POLL_GAP) ? 2 * NUM_BITS : POLL_GAP;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam logic [CntW-1:0] LastLatch = CntW'(1);
  localparam logic [CntW-1:0] LastBit   = CntW'(2 * NUM_BITS - 1);
  localparam logic [CntW-1:0] LastGap   = CntW'(POLL_GAP - 1);

  logic                               tick;
  logic [NUM_PADS-1:0]                smp;
  pad_state_e                         state_q;
  logic [CntW-1:0]                    ctr_q;
  logic                               latch_q;
  logic                               pad_clk_q;
  logic                               pub_q;
  logic                               valid_q;
  logic [NUM_PADS-1:0]                changed_q;
  logic [NUM_PADS-1:0][NUM_BITS-1:0]  sh_q;
  logic [NUM_PADS-1:0][NUM_BITS-1:0]  buttons_q;

  pad_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign smp     = ACTIVE_LOW ? ~data : data;
  assign latch   = latch_q;
  assign pad_clk = pad_clk_q;
  assign buttons = buttons_q;
  assign valid   = valid_q;
  assign changed = changed_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ctr_q     <= '0;
      latch_q   <= 1'b0;
      pad_clk_q <= 1'b1;
      pub_q     <= 1'b0;
      valid_q   <= 1'b0;
      changed_q <= '0;
      sh_q      <= '0;
      buttons_q <= '0;
    end else begin
      valid_q <= pub_q;
      pub_q   <= 1'b0;
      if (pub_q) begin
        buttons_q <= sh_q;
        for (int p = 0; p < NUM_PADS; p++) begin
          changed_q[p] <= (sh_q[p] != buttons_q[p]);
        end
      end
      if (tick) begin
        unique case (state_q)
          StIdle: begin
            if (enable) begin
              state_q <= StLatch;
              latch_q <= 1'b1;
              ctr_q   <= '0;
            end
          end
          StLatch: begin
            if (ctr_q == LastLatch) begin
              state_q <= StShift;
              latch_q <= 1'b0;
              ctr_q   <= '0;
            end else begin
              ctr_q <= ctr_q + CntW'(1);
            end
          end
          StShift: begin
            // Even ticks sample and drop pad_clk; new bit enters at the MSB so bit k ends at k.
            if (!ctr_q[0]) begin
              pad_clk_q <= 1'b0;
              for (int p = 0; p < NUM_PADS; p++) begin
                sh_q[p] <= (sh_q[p] >> 1) | (NUM_BITS'(smp[p]) << (NUM_BITS - 1));
              end
            end else begin
              pad_clk_q <= 1'b1;
            end
            if (ctr_q == LastBit) begin
              state_q <= StGap;
              ctr_q   <= '0;
              pub_q   <= 1'b1;
            end else begin
              ctr_q <= ctr_q + CntW'(1);
            end
          end
          StGap: begin
            if (ctr_q == LastGap) begin
              ctr_q <= '0;
              if (enable) begin
                state_q <= StLatch;
                latch_q <= 1'b1;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              ctr_q <= ctr_q + CntW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pad_poller.sv
// Directed bench: three poller configurations fed by simple shift-register pad emulators.
module tb_pad_poller;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  always #5 clk = ~clk;

  // A: 2 pads, 8 bits, active-low. B: 16 bits. C: active-high.
  logic        latch_a, pc_a, val_a;
  logic [15:0] btn_a;
  logic [1:0]  chg_a, data_a;
  logic        latch_b, pc_b, val_b;
  logic [31:0] btn_b;
  logic [1:0]  chg_b, data_b;
  logic        latch_c, pc_c, val_c;
  logic [15:0] btn_c;
  logic [1:0]  chg_c, data_c;

  // Serial frames: bit k is the k-th bit shifted out of the pad.
  logic [31:0] fa0, fa1, fb0, fb1, fc0, fc1;
  logic [4:0]  ia = '0, ib = '0, ic = '0;

  always @(posedge latch_a or posedge pc_a) if (latch_a) ia <= '0; else ia <= ia + 5'd1;
  always @(posedge latch_b or posedge pc_b) if (latch_b) ib <= '0; else ib <= ib + 5'd1;
  always @(posedge latch_c or posedge pc_c) if (latch_c) ic <= '0; else ic <= ic + 5'd1;

  assign data_a = {fa1[ia], fa0[ia]};
  assign data_b = {fb1[ib], fb0[ib]};
  assign data_c = {fc1[ic], fc0[ic]};

  pad_poller #(.NUM_PADS(2), .NUM_BITS(8), .DIV(4), .POLL_GAP(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .data(data_a), .latch(latch_a),
    .pad_clk(pc_a), .buttons(btn_a), .valid(val_a), .changed(chg_a)
  );

  pad_poller #(.NUM_PADS(2), .NUM_BITS(16), .DIV(4), .POLL_GAP(4), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .data(data_b), .latch(latch_b),
    .pad_clk(pc_b), .buttons(btn_b), .valid(val_b), .changed(chg_b)
  );

  pad_poller #(.NUM_PADS(2), .NUM_BITS(8), .DIV(4), .POLL_GAP(4), .ACTIVE_LOW(1'b0)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .data(data_c), .latch(latch_c),
    .pad_clk(pc_c), .buttons(btn_c), .valid(val_c), .changed(chg_c)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          va_n[$], vb_n[$], vc_n[$];
  logic [15:0] va_btn[$], vc_btn[$];
  logic [31:0] vb_btn[$];
  logic [1:0]  va_chg[$], vb_chg[$];
  int          first_latch, latch_b_len, pulses_b, bad_width_b, run_b, idle_bad, rst_first;
  int          rst_cnt;
  logic [15:0] rst_btn;
  logic [1:0]  rst_chg;

  initial begin
    fa0 = 32'hFFFF_FFFE;  // 0,1,1,1,... -> only button 0 pressed
    fa1 = 32'hFFFF_FFFF;
    fb0 = 32'hAAAA_AAAA;  // 0,1,0,1,... from the first bit
    fb1 = 32'hFFFF_FFFF;
    fc0 = 32'h0000_0001;  // 1,0,0,... with active-high pads
    fc1 = 32'h0000_0000;
    first_latch = -1; latch_b_len = 0; pulses_b = 0; bad_width_b = 0; run_b = 0;
    idle_bad = 0; rst_first = -1; rst_cnt = 0; rst_btn = '0; rst_chg = '0;

    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_latch",   {63'd0, latch_a}, 64'd0);
    chk("rst_pad_clk", {63'd0, pc_a},    64'd1);
    chk("rst_buttons", {48'd0, btn_a},   64'd0);
    chk("rst_valid",   {63'd0, val_a},   64'd0);
    chk("rst_changed", {62'd0, chg_a},   64'd0);

    enable = 1'b1;
    reset  = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (latch_a && first_latch < 0) first_latch = n;
      if (n <= 150) begin
        if (latch_b) latch_b_len++;
        if (!pc_b) run_b++;
        else if (run_b > 0) begin
          pulses_b++;
          if (run_b != 4) bad_width_b++;
          run_b = 0;
        end
      end
      if (val_a) begin va_n.push_back(n); va_btn.push_back(btn_a); va_chg.push_back(chg_a); end
      if (val_b) begin vb_n.push_back(n); vb_btn.push_back(btn_b); vb_chg.push_back(chg_b); end
      if (val_c) begin vc_n.push_back(n); vc_btn.push_back(btn_c); end
      if (n >= 270 && (latch_a !== 1'b0 || pc_a !== 1'b1)) idle_bad++;
      if (n == 212) enable = 1'b0;  // right after shift tick 5 of A's third frame
    end

    chk("first_tick_latch", 64'(first_latch), 64'd4);
    chk("latch_b_len",      64'(latch_b_len), 64'd8);
    chk("pad_clk_b_pulses", 64'(pulses_b),    64'd16);
    chk("pad_clk_b_width",  64'(bad_width_b), 64'd0);

    chk("a_valid_count", 64'(va_n.size()), 64'd3);
    chk("a_valid0_time", 64'(va_n[0]),     64'd77);
    chk("a_buttons0",    {48'd0, va_btn[0]}, 64'h0001);
    chk("a_changed0",    {62'd0, va_chg[0]}, 64'd1);
    chk("a_valid1_time", 64'(va_n[1]),     64'd165);
    chk("a_buttons1",    {48'd0, va_btn[1]}, 64'h0001);
    chk("a_changed1",    {62'd0, va_chg[1]}, 64'd0);
    chk("a_valid2_time", 64'(va_n[2]),     64'd253);
    chk("a_idle_hold",   64'(idle_bad),    64'd0);

    chk("b_valid_count", 64'(vb_n.size()), 64'd2);
    chk("b_valid0_time", 64'(vb_n[0]),     64'd141);
    chk("b_buttons0",    {32'd0, vb_btn[0]}, 64'h5555);
    chk("b_changed0",    {62'd0, vb_chg[0]}, 64'd1);
    chk("b_valid1_time", 64'(vb_n[1]),     64'd293);

    chk("c_valid_count", 64'(vc_n.size()), 64'd3);
    chk("c_buttons0",    {48'd0, vc_btn[0]}, 64'h0001);

    // Restart polling, then hit reset in the middle of the shift phase.
    enable = 1'b1;
    repeat (30) @(negedge clk);
    chk("pre_reset_buttons", {48'd0, btn_a}, 64'h0001);
    reset = 1'b1;
    #1;
    chk("mid_rst_latch",   {63'd0, latch_a}, 64'd0);
    chk("mid_rst_pad_clk", {63'd0, pc_a},    64'd1);
    chk("mid_rst_buttons", {48'd0, btn_a},   64'd0);
    chk("mid_rst_valid",   {63'd0, val_a},   64'd0);
    chk("mid_rst_changed", {62'd0, chg_a},   64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (val_a) begin
        rst_cnt++;
        if (rst_first < 0) begin rst_first = n; rst_btn = btn_a; rst_chg = chg_a; end
      end
    end
    chk("post_rst_valid_time", 64'(rst_first), 64'd77);
    chk("post_rst_valid_cnt",  64'(rst_cnt),   64'd1);
    chk("post_rst_buttons",    {48'd0, rst_btn}, 64'h0001);
    chk("post_rst_changed",    {62'd0, rst_chg}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
